// File: rtl/stack_pkg.sv
// Shared encodings for the stack request controller: op codes, response status codes, FSM states.
package stack_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_OVF = 2'b01,
        ST_UNF = 2'b10,
        ST_ERR = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/stack_occ_counter.sv
// Shadow occupancy counter, 0..DEPTH, saturating at both ends; full/empty flags are combinational.
// Latency: count updates one cycle after inc/dec. No backpressure; inc at full and dec at empty are ignored.
module stack_occ_counter #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   dec,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CW'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/stack_req_ctrl.sv
// Request front-end for an 8-bit LIFO: one push/pop pulse per accepted request, shadow occupancy, status response.
// Latency accept->rsp_valid: push 3, pop 2+POP_LATENCY, rejected 1. Response held until rsp_ready; one request in flight.
// Optional statistics counters are built only when STACK_REQ_CTRL_STATS_EN is defined.
module stack_req_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int POP_LATENCY = 1,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [DATA_WIDTH-1:0]  req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic [1:0]             rsp_status,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic [DATA_WIDTH-1:0]  stk_data_in,
    input  logic [DATA_WIDTH-1:0]  stk_data_out,
    input  logic                   stk_error,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [STAT_WIDTH-1:0]  stat_push,
    output logic [STAT_WIDTH-1:0]  stat_pop,
    output logic [STAT_WIDTH-1:0]  stat_rej
);

    localparam int WCW = (POP_LATENCY > 1) ? $clog2(POP_LATENCY + 1) : 1;

    state_e                  state_q, state_d;
    logic                    run_q;
    op_e                     op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [WCW-1:0]          wait_q;
    logic                    accept, reject, wait_last;
    logic                    occ_inc, occ_dec, occ_full, occ_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        wait_last = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // run_q keeps req_ready low for the first cycle out of reset
                req_ready = run_q;
                if (req_valid && run_q) begin
                    accept  = 1'b1;
                    reject  = ((op_e'(req_op) == OP_PUSH) && occ_full) ||
                              ((op_e'(req_op) == OP_POP)  && occ_empty);
                    state_d = reject ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                stk_push = (op_q == OP_PUSH);
                stk_pop  = (op_q == OP_POP);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WCW'(1)) begin
                    wait_last = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            op_q       <= OP_PUSH;
            data_q     <= '0;
            wait_q     <= '0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                op_q   <= op_e'(req_op);
                data_q <= req_data;
                if (reject) begin
                    rsp_data   <= '0;
                    rsp_status <= (op_e'(req_op) == OP_PUSH) ? ST_OVF : ST_UNF;
                end
            end
            if (state_q == S_ISSUE) begin
                wait_q <= (op_q == OP_POP) ? WCW'(POP_LATENCY) : WCW'(1);
            end else if (state_q == S_WAIT && !wait_last) begin
                wait_q <= wait_q - WCW'(1);
            end
            if (wait_last) begin
                if (stk_error) begin
                    rsp_data   <= '0;
                    rsp_status <= ST_ERR;
                end else begin
                    rsp_data   <= (op_q == OP_POP) ? stk_data_out : '0;
                    rsp_status <= ST_OK;
                end
            end
        end
    end

    assign stk_data_in = data_q;
    assign occ_inc     = wait_last && !stk_error && (op_q == OP_PUSH);
    assign occ_dec     = wait_last && !stk_error && (op_q == OP_POP);

    stack_occ_counter #(
        .DEPTH (DEPTH)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .inc   (occ_inc),
        .dec   (occ_dec),
        .count (occupancy),
        .full  (occ_full),
        .empty (occ_empty)
    );

`ifdef STACK_REQ_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] push_q, pop_q, rej_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_q <= '0;
            pop_q  <= '0;
            rej_q  <= '0;
        end else begin
            if (occ_inc && !(&push_q)) push_q <= push_q + STAT_WIDTH'(1);
            if (occ_dec && !(&pop_q))  pop_q  <= pop_q + STAT_WIDTH'(1);
            if (reject && !(&rej_q))   rej_q  <= rej_q + STAT_WIDTH'(1);
        end
    end

    assign stat_push = push_q;
    assign stat_pop  = pop_q;
    assign stat_rej  = rej_q;
`else
    assign stat_push = '0;
    assign stat_pop  = '0;
    assign stat_rej  = '0;
`endif

endmodule

// File: tb/tb_stack_req_ctrl.sv
// Directed plus randomized bench for stack_req_ctrl against a queue-based LIFO reference model.
module tb_stack_req_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int PLAT  = 1;
    localparam int SW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_op;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic          stk_push, stk_pop;
    logic [DW-1:0] stk_data_in, stk_data_out;
    logic          stk_error;
    logic [4:0]    occupancy;
    logic [SW-1:0] stat_push, stat_pop, stat_rej;

    always #5 clk = ~clk;

    stack_req_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .POP_LATENCY(PLAT), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_error(stk_error),
        .occupancy(occupancy), .stat_push(stat_push), .stat_pop(stat_pop), .stat_rej(stat_rej)
    );

    // Environment: the physical stack the controller drives (pop data one cycle after the pulse).
    logic [DW-1:0] mem[$];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.delete();
            stk_data_out <= '0;
        end else begin
            if (stk_push) mem.push_back(stk_data_in);
            if (stk_pop && mem.size() > 0) stk_data_out <= mem.pop_back();
        end
    end

    int acc_cnt = 0, push_cnt = 0, pop_cnt = 0, both_cnt = 0, dbl_cnt = 0;
    int ok_cnt = 0, ovf_cnt = 0;
    logic prev_push = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            if (req_valid && req_ready) acc_cnt++;
            if (stk_push) push_cnt++;
            if (stk_pop) pop_cnt++;
            if (stk_push && stk_pop) both_cnt++;
            if (stk_push && prev_push) dbl_cnt++;
            if (rsp_valid && rsp_ready && rsp_status == 2'b00) ok_cnt++;
            if (rsp_valid && rsp_ready && rsp_status == 2'b01) ovf_cnt++;
        end
        prev_push = stk_push;
    end

    // Reference model: the stack contents the controller is expected to believe in.
    logic [DW-1:0] model[$];
    int e_push = 0, e_pop = 0, e_rej = 0;
    int passed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_stat(input int v);
`ifdef STACK_REQ_CTRL_STATS_EN
        return (v > 65535) ? 32'hFFFF : 32'(v);
`else
        return (v > 65535) ? 32'h0 : 32'h0 & 32'(v);
`endif
    endfunction

    task automatic chk_stats();
        chk("stat_push", stat_push, exp_stat(e_push));
        chk("stat_pop",  stat_pop,  exp_stat(e_pop));
        chk("stat_rej",  stat_rej,  exp_stat(e_rej));
    endtask

    task automatic do_req(input logic op, input logic [DW-1:0] d, input int hold, input logic err);
        logic [DW-1:0] exp_d, d0;
        logic [1:0]    exp_s, s0;
        int            exp_lat, exp_pu, exp_po, lat, n, p0, q0;
        logic          stable;
        exp_d = '0; exp_pu = 0; exp_po = 0;
        if (op == 1'b0) begin
            if (model.size() == DEPTH) begin
                exp_s = 2'b01; exp_lat = 1; e_rej++;
            end else begin
                exp_lat = 3; exp_pu = 1;
                if (err) exp_s = 2'b11;
                else begin exp_s = 2'b00; model.push_back(d); e_push++; end
            end
        end else begin
            if (model.size() == 0) begin
                exp_s = 2'b10; exp_lat = 1; e_rej++;
            end else begin
                exp_lat = 2 + PLAT; exp_po = 1;
                if (err) exp_s = 2'b11;
                else begin exp_s = 2'b00; exp_d = model.pop_back(); e_pop++; end
            end
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_data = d; stk_error = err; rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_ready", req_ready, 1);
        p0 = push_cnt; q0 = pop_cnt;
        @(negedge clk);
        req_valid = 1'b0; req_data = DW'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("latency", lat, exp_lat);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_status", rsp_status, exp_s);
        if (hold > 0) begin
            d0 = rsp_data; s0 = rsp_status; stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== d0 || rsp_status !== s0 || req_ready) stable = 1'b0;
            end
            chk("rsp_hold", stable, 1);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("rsp_done", rsp_valid, 0);
        stk_error = 1'b0;
        chk("push_pulses", push_cnt - p0, exp_pu);
        chk("pop_pulses", pop_cnt - q0, exp_po);
        chk("occupancy", occupancy, model.size());
        chk_stats();
    endtask

    initial begin
        int a0, p0, o0, v0, acc;
        reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_data = '0;
        rsp_ready = 1'b1; stk_error = 1'b0;
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_stk", {stk_push, stk_pop}, 0);
        chk("rst_rsp", {rsp_data, rsp_status}, 0);
        chk("rst_occ", occupancy, 0);
        chk_stats();
        @(negedge clk); reset = 1'b1;

        // Fill, overflow, drain in LIFO order, underflow.
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, DW'(i), 0, 1'b0);
        do_req(1'b0, 8'hAA, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, '0, 0, 1'b0);
        do_req(1'b1, '0, 0, 1'b0);

        // Held req_valid: one pulse per acceptance, then only overflow rejects.
        a0 = acc_cnt; p0 = push_cnt; o0 = ok_cnt; v0 = ovf_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_data = 8'hFF; rsp_ready = 1'b1;
        repeat (3000) @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        acc = acc_cnt - a0;
        for (int i = 0; i < DEPTH; i++) model.push_back(8'hFF);
        e_push += DEPTH; e_rej += acc - DEPTH;
        chk("hold_pushes", push_cnt - p0, DEPTH);
        chk("hold_ok", ok_cnt - o0, DEPTH);
        chk("hold_ovf", ovf_cnt - v0, acc - DEPTH);
        chk("hold_many_acc", acc > DEPTH, 1);
        chk("hold_occ", occupancy, DEPTH);
        chk_stats();

        // Response back-pressure on a pop.
        do_req(1'b1, '0, 10, 1'b0);

        // Random mix against the model.
        for (int i = 0; i < 80; i++)
            do_req(1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 3), 1'b0);

        // Stack error during a push.
        if (model.size() == DEPTH) do_req(1'b1, '0, 0, 1'b0);
        do_req(1'b0, 8'h3C, 0, 1'b1);

        // Reset in the middle of an ISSUE cycle.
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_data = 8'h5A; rsp_ready = 1'b1;
        begin
            int n = 0;
            while (!req_ready && n < 50) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("issue_pulse", stk_push, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", {req_ready, rsp_valid, stk_push, stk_pop}, 0);
        chk("mid_rst_rsp", {rsp_data, rsp_status}, 0);
        chk("mid_rst_occ", occupancy, 0);
        model.delete(); e_push = 0; e_pop = 0; e_rej = 0;
        chk_stats();
        @(negedge clk); reset = 1'b1;
        p0 = push_cnt; o0 = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) o0++; end
        chk("no_stale_rsp", o0, 0);
        chk("no_stale_push", push_cnt - p0, 0);
        do_req(1'b0, 8'h11, 0, 1'b0);
        do_req(1'b1, '0, 0, 1'b0);

        chk("never_both", both_cnt, 0);
        chk("single_cycle", dbl_cnt, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
